// File: rtl/disp_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan controller.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [NUM_DIGITS-1:0] digit_vec_t;

  localparam digit_vec_t SEL_RST = 4'b0001;
  localparam digit_vec_t AN_OFF  = 4'b1111;

  function automatic logic onehot_ok(input digit_vec_t sel);
    return $onehot(sel);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Refresh prescaler: counts 0..DIV-1, flags the terminal count and emits a
// registered one-cycle tick on the cycle after it.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("tick_gen: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  assign wrap = (cnt_q == LAST);
  assign tick = tick_q;

  // NOTE: defaults come first so every path assigns every output; no latch inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (wrap) cnt_d = '0;
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner: rotating one-hot select, binary
// index and active-low anodes. Optional leading-zero blanking: LEADING_ZERO_BLANK_EN.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int DIGIT_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [15:0]           val,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [1:0]            digit_idx,
  output logic                  tick
);

  localparam int DIV = CLK_HZ / DIGIT_HZ;

  logic       adv;
  digit_vec_t sel_q, sel_d;
  digit_vec_t an_q, an_d;
  digit_vec_t blank;
  logic [1:0] idx_q, idx_d;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .wrap  (adv)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i goes dark when it and every higher nibble are zero; digit 0 always shows.
  assign blank = {val[15:12] == 4'h0, val[15:8] == 8'h00, val[15:4] == 12'h000, 1'b0};
`else
  logic unused_val;
  assign unused_val = ^val;
  assign blank      = '0;
`endif

  always_comb begin
    sel_d = sel_q;
    idx_d = idx_q;
    if (adv) begin
      if (onehot_ok(sel_q)) begin
        sel_d = {sel_q[NUM_DIGITS-2:0], sel_q[NUM_DIGITS-1]};
        idx_d = idx_q + 2'd1;
      end else begin
        // A corrupted select snaps back to digit 0 at the next advance.
        sel_d = SEL_RST;
        idx_d = '0;
      end
    end
    an_d = en ? (~sel_d | blank) : AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_RST;
      idx_q <= '0;
      an_q  <= AN_OFF;
    end else begin
      sel_q <= sel_d;
      idx_q <= idx_d;
      an_q  <= an_d;
    end
  end

  assign sel       = sel_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed scoreboard bench for digit_scan_ctrl at DIV=4; expectations for each
// digit advance are queued with the stimulus and checked when tick appears.
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] val;
  logic [3:0]  sel;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        tick;

  digit_scan_ctrl #(.CLK_HZ(4), .DIGIT_HZ(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .val       (val),
    .sel       (sel),
    .an        (an),
    .digit_idx (digit_idx),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] sel;
    logic [3:0] an;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   n_checks = 0;
  int   mark     = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tick(input logic [1:0] idx, input logic [3:0] s,
                             input logic [3:0] a, input int gap);
    exp_t e;
    e.idx = idx;
    e.sel = s;
    e.an  = a;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Advance at least one cycle, then wait (bounded) for the next tick and score it.
  task automatic wait_tick(input string tag);
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 16);
    e = sb.pop_front();
    check({tag, "_seen"}, 16'(tick), 16'd1);
    if (tick === 1'b1) begin
      check({tag, "_gap"}, 16'(cyc - mark), 16'(e.gap));
      check({tag, "_sel"}, 16'(sel), 16'(e.sel));
      check({tag, "_idx"}, 16'(digit_idx), 16'(e.idx));
      check({tag, "_an"},  16'(an), 16'(e.an));
      mark = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    val   = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_sel",  16'(sel), 16'h1);
    check("rst_idx",  16'(digit_idx), 16'h0);
    check("rst_an",   16'(an), 16'hF);
    check("rst_tick", 16'(tick), 16'h0);

    // Reset release: first advance four cycles later, then a steady rotation.
    rst_n = 1'b1;
    mark  = cyc;
    @(negedge clk);
    check("lit_d0_an", 16'(an), 16'hE);
    expect_tick(2'd1, 4'b0010, 4'b1101, 4);
    expect_tick(2'd2, 4'b0100, 4'b1011, 4);
    expect_tick(2'd3, 4'b1000, 4'b0111, 4);
    expect_tick(2'd0, 4'b0001, 4'b1110, 4);
    wait_tick("scan1");
    @(negedge clk);
    check("tick_pulse_width", 16'(tick), 16'h0);
    wait_tick("scan2");
    wait_tick("scan3");
    wait_tick("scan4");

    // Blank for eight cycles while the rotation keeps going.
    en = 1'b0;
    @(negedge clk);
    check("blank_first_edge", 16'(an), 16'hF);
    expect_tick(2'd1, 4'b0010, 4'b1111, 4);
    expect_tick(2'd2, 4'b0100, 4'b1111, 4);
    wait_tick("blank1");
    @(negedge clk);
    check("blank_mid", 16'(an), 16'hF);
    wait_tick("blank2");

    // Re-enable relights the current digit on the next edge, phase untouched.
    en = 1'b1;
    @(negedge clk);
    check("relight_an",  16'(an), 16'hB);
    check("relight_sel", 16'(sel), 16'h4);
    expect_tick(2'd3, 4'b1000, 4'b0111, 4);
    expect_tick(2'd0, 4'b0001, 4'b1110, 4);
    expect_tick(2'd1, 4'b0010, 4'b1101, 4);
    wait_tick("resume1");
    wait_tick("resume2");
    wait_tick("resume3");

    // Corrupt the select; the next advance must restore digit 0.
    dut.sel_q = 4'b0110;
    expect_tick(2'd0, 4'b0001, 4'b1110, 4);
    expect_tick(2'd1, 4'b0010, 4'b1101, 4);
    wait_tick("recover");
    wait_tick("post_recover");

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_sel",  16'(sel), 16'h1);
    check("async_idx",  16'(digit_idx), 16'h0);
    check("async_an",   16'(an), 16'hF);
    check("async_tick", 16'(tick), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mark  = cyc;
    expect_tick(2'd1, 4'b0010, 4'b1101, 4);
    wait_tick("after_rst");

`ifdef LEADING_ZERO_BLANK_EN
    val = 16'h0042;
    expect_tick(2'd2, 4'b0100, 4'b1111, 4);
    expect_tick(2'd3, 4'b1000, 4'b1111, 4);
    expect_tick(2'd0, 4'b0001, 4'b1110, 4);
    expect_tick(2'd1, 4'b0010, 4'b1101, 4);
    wait_tick("lzb42_d2");
    wait_tick("lzb42_d3");
    wait_tick("lzb42_d0");
    wait_tick("lzb42_d1");
    val = 16'h0000;
    expect_tick(2'd2, 4'b0100, 4'b1111, 4);
    expect_tick(2'd3, 4'b1000, 4'b1111, 4);
    expect_tick(2'd0, 4'b0001, 4'b1110, 4);
    expect_tick(2'd1, 4'b0010, 4'b1111, 4);
    wait_tick("lzb0_d2");
    wait_tick("lzb0_d3");
    wait_tick("lzb0_d0");
    wait_tick("lzb0_d1");
`else
    val = 16'h0000;
    expect_tick(2'd2, 4'b0100, 4'b1011, 4);
    expect_tick(2'd3, 4'b1000, 4'b0111, 4);
    expect_tick(2'd0, 4'b0001, 4'b1110, 4);
    expect_tick(2'd1, 4'b0010, 4'b1101, 4);
    wait_tick("zero_d2");
    wait_tick("zero_d3");
    wait_tick("zero_d0");
    wait_tick("zero_d1");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
